button_debounce_queue: RTL

Front-end conditioning stage for the 16 front-panel pushbuttons. It synchronises raw asynchronous button inputs and debounces each one against a shared millisecond-scale tick. Press events are queued so the block emits at most one press per cycle as a single-cycle one-hot pulse on `buttons`. It sits directly upstream of the button encoder that maps one-hot presses to `freqSelect`/`lowpassSelect`/`highpassSelect`. That encoder latches only exactly-one-hot words and holds on all-zero, which this block guarantees.

---
 rtl/button_pkg.sv | 13 +
 rtl/button_debounce_cell.sv | 48 ++++
 rtl/button_debounce_queue.sv | 73 +++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and helpers for the front-panel button conditioning path.
package button_pkg;

    localparam int unsigned NUM_BUTTONS = 16;

    typedef logic [NUM_BUTTONS-1:0] button_vec_t;

    // Isolate the lowest set bit; index 0 wins arbitration.
    function automatic button_vec_t lowest_onehot(input button_vec_t v);
        return v & (-v);
    endfunction

endpackage

// File: rtl/button_debounce_cell.sv
// One button: 2-flop synchroniser plus tick-based debounce counter and stable level.
module button_debounce_cell #(
    parameter int unsigned DEBOUNCE_TICKS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic tick,
    output logic stable,
    output logic stable_next_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next_c;

    // Any return to the stable level restarts the count.
    always_comb begin
        stable_next_c = stable;
        cnt_next_c    = cnt;
        if (sync_q2 == stable) begin
            cnt_next_c = '0;
        end else if (tick && (cnt == CNT_W'(DEBOUNCE_TICKS - 1))) begin
            stable_next_c = sync_q2;
            cnt_next_c    = '0;
        end else if (tick) begin
            cnt_next_c = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            stable  <= 1'b0;
        end else begin
            sync_q1 <= level;
            sync_q2 <= sync_q1;
            cnt     <= cnt_next_c;
            stable  <= stable_next_c;
        end
    end

endmodule

// File: rtl/button_debounce_queue.sv
// Debounces 16 pushbuttons and serialises press events into single-cycle one-hot pulses.
module button_debounce_queue
    import button_pkg::*;
#(
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 10,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons_raw,
    output logic [NUM_BUTTONS-1:0] buttons,
    output logic [NUM_BUTTONS-1:0] pressed
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0] pre_cnt;
    logic             tick_c;
    button_vec_t      norm_c;
    button_vec_t      stable_q;
    button_vec_t      stable_next_c;
    button_vec_t      rise_c;
    button_vec_t      grant_c;
    button_vec_t      pending;
    button_vec_t      pending_next_c;

    // Shared debounce tick prescaler.
    assign tick_c = (pre_cnt == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (tick_c) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    assign norm_c = ACTIVE_LOW ? ~buttons_raw : buttons_raw;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_cell
        button_debounce_cell #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_cell (
            .clk          (clk),
            .reset        (reset),
            .level        (norm_c[i]),
            .tick         (tick_c),
            .stable       (stable_q[i]),
            .stable_next_c(stable_next_c[i])
        );
    end

    // Presses only; releases never queue an event.
    assign rise_c         = stable_next_c & ~stable_q;
    assign grant_c        = lowest_onehot(pending);
    assign pending_next_c = (pending & ~grant_c) | rise_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            buttons <= '0;
        end else begin
            pending <= pending_next_c;
            buttons <= grant_c;
        end
    end

    assign pressed = stable_q;

endmodule
